// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//
// Control block for an external program counter. The PC either increments
// (PCincr=1) or loads pc_data (PCincr=0) on every clock, so "hold" is done by
// loading the PC's own current value back into it. The sequencer provides
// straight-line fetch, JMP, JCOND, CALL/RET through a small return-address
// stack, timed WAIT holds, HALT, an external stall, and a FAULT state for
// stack overflow/underflow.
//
// Ports:
//   clk       system clock, all state on rising edge
//   reset     asynchronous, active-high reset
//   op        decoded op for the instruction at pc_value
//             (0 NEXT, 1 JMP, 2 JCOND, 3 CALL, 4 RET, 5 WAIT, 6 HALT, 7 = NEXT)
//   target    jump/call target; WAIT count in target[WAIT_W-1:0]
//   cond      JCOND condition (1 = taken)
//   stall     freeze request from the datapath
//   pc_value  current PC, fed back
//   PCincr    1 = PC increments, 0 = PC loads pc_data
//   pc_data   PC load value (0 whenever PCincr=1)
//   halted    registered, 1 while in HALT
//   fault     registered, 1 while in FAULT
//   depth     return-address stack occupancy, 0..STACK_DEPTH
// -----------------------------------------------------------------------------
module pc_sequencer #(
    parameter int AW          = 8,
    parameter int STACK_DEPTH = 4,
    parameter int WAIT_W      = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [2:0]    op,
    input  logic [AW-1:0] target,
    input  logic          cond,
    input  logic          stall,
    input  logic [AW-1:0] pc_value,
    output logic          PCincr,
    output logic [AW-1:0] pc_data,
    output logic          halted,
    output logic          fault,
    output logic [2:0]    depth
);

    localparam int         SW   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [2:0] FULL = 3'(STACK_DEPTH);

    localparam logic [2:0] OP_JMP   = 3'd1;
    localparam logic [2:0] OP_JCOND = 3'd2;
    localparam logic [2:0] OP_CALL  = 3'd3;
    localparam logic [2:0] OP_RET   = 3'd4;
    localparam logic [2:0] OP_WAIT  = 3'd5;
    localparam logic [2:0] OP_HALT  = 3'd6;

    typedef enum logic [1:0] {S_RUN, S_WAIT, S_HALT, S_FAULT} state_t;

    state_t              state_q, state_d;
    logic [2:0]          depth_q, depth_d;
    logic [WAIT_W-1:0]   cnt_q, cnt_d;
    logic                halted_q, fault_q;
    logic [AW-1:0]       stack_q [STACK_DEPTH];

    logic                incr;
    logic                push;
    logic [AW-1:0]       load_data;
    logic [AW-1:0]       pc_plus1;
    logic [WAIT_W-1:0]   wait_n;
    logic [SW-1:0]       push_idx;
    logic [SW-1:0]       top_idx;

    assign pc_plus1 = pc_value + {{(AW-1){1'b0}}, 1'b1};
    assign wait_n   = target[WAIT_W-1:0];
    assign push_idx = SW'(depth_q);
    assign top_idx  = SW'(depth_q - 3'd1);

    // Next-state and PC control. Default is "hold": load pc_value back.
    always_comb begin
        state_d   = state_q;
        depth_d   = depth_q;
        cnt_d     = cnt_q;
        push      = 1'b0;
        incr      = 1'b0;
        load_data = pc_value;
        case (state_q)
            S_RUN: begin
                if (!stall) begin
                    case (op)
                        OP_JMP:   load_data = target;
                        OP_JCOND: begin
                            if (cond) load_data = target;
                            else      incr = 1'b1;
                        end
                        OP_CALL: begin
                            if (depth_q == FULL) begin
                                state_d = S_FAULT;
                            end else begin
                                push      = 1'b1;
                                depth_d   = depth_q + 3'd1;
                                load_data = target;
                            end
                        end
                        OP_RET: begin
                            if (depth_q == 3'd0) begin
                                state_d = S_FAULT;
                            end else begin
                                depth_d   = depth_q - 3'd1;
                                load_data = stack_q[top_idx];
                            end
                        end
                        OP_WAIT: begin
                            if (wait_n == '0) begin
                                incr = 1'b1;
                            end else begin
                                cnt_d   = wait_n;
                                state_d = S_WAIT;
                            end
                        end
                        OP_HALT:  state_d = S_HALT;
                        default:  incr = 1'b1;  // NEXT and reserved op
                    endcase
                end
            end
            S_WAIT: begin
                if (!stall) begin
                    if (cnt_q == WAIT_W'(1)) begin
                        incr    = 1'b1;
                        state_d = S_RUN;
                    end else begin
                        cnt_d = cnt_q - WAIT_W'(1);
                    end
                end
            end
            default: ;  // HALT and FAULT hold until reset
        endcase
    end

    // During reset the PC is forced to load 0 on every edge.
    assign PCincr  = reset ? 1'b0 : incr;
    assign pc_data = (reset || incr) ? '0 : load_data;
    assign halted  = halted_q;
    assign fault   = fault_q;
    assign depth   = depth_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_RUN;
            depth_q  <= 3'd0;
            cnt_q    <= '0;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            depth_q  <= depth_d;
            cnt_q    <= cnt_d;
            halted_q <= (state_d == S_HALT);
            fault_q  <= (state_d == S_FAULT);
        end
    end

    // Stack entries are intentionally not cleared by reset; only depth is.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            stack_q[push_idx] <= pc_plus1;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
//
// Directed testbench for pc_sequencer. The bench owns a simple PC register
// (increment or load on every edge) whose value is fed back to the sequencer.
// Each scenario task drives stimulus and checks expected values inline.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

    localparam logic [2:0] NEXT = 3'd0, JMP = 3'd1, JCOND = 3'd2, CALL = 3'd3,
                           RET  = 3'd4, WAITOP = 3'd5, HALT = 3'd6, RSVD = 3'd7;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] op = NEXT;
    logic [7:0] target = 8'h00;
    logic       cond = 1'b0;
    logic       stall = 1'b0;
    logic [7:0] pc = 8'h00;
    logic       PCincr;
    logic [7:0] pc_data;
    logic       halted;
    logic       fault;
    logic [2:0] depth;

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    // Program counter being sequenced.
    always @(posedge clk) pc <= PCincr ? pc + 8'd1 : pc_data;

    pc_sequencer #(.AW(8), .STACK_DEPTH(4), .WAIT_W(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .op       (op),
        .target   (target),
        .cond     (cond),
        .stall    (stall),
        .pc_value (pc),
        .PCincr   (PCincr),
        .pc_data  (pc_data),
        .halted   (halted),
        .fault    (fault),
        .depth    (depth)
    );

    // One clock with the given inputs; returns 1ns after the edge.
    task automatic step(input logic [2:0] o, input logic [7:0] t,
                        input logic c, input logic s);
        op = o; target = t; cond = c; stall = s;
        @(posedge clk); #1;
        $display("[TB] op=%0d tgt=%02h cond=%0b stall=%0b -> pc=%02h depth=%0d halted=%0b fault=%0b",
                 o, t, c, s, pc, depth, halted, fault);
    endtask

    task automatic do_reset();
        reset = 1'b1; op = NEXT; stall = 1'b0; cond = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (PCincr !== 1'b0 || pc_data !== 8'h00) begin failed++;
            $display("FAIL reset_drive: PCincr=%0b pc_data=%02h, need 0/00", PCincr, pc_data); end
        tests++; if (pc !== 8'h00) begin failed++;
            $display("FAIL reset_pc: pc=%02h, need 00", pc); end
        tests++; if (halted !== 1'b0 || fault !== 1'b0 || depth !== 3'd0) begin failed++;
            $display("FAIL reset_flags: halted=%0b fault=%0b depth=%0d, need 0/0/0", halted, fault, depth); end
        reset = 1'b0;
    endtask

    task automatic test_next();
        logic [7:0] exp_wrap [3];
        exp_wrap[0] = 8'hFF; exp_wrap[1] = 8'h00; exp_wrap[2] = 8'h01;
        do_reset();
        op = NEXT; stall = 1'b0; #1;
        tests++; if (PCincr !== 1'b1 || pc_data !== 8'h00) begin failed++;
            $display("FAIL next_drive: PCincr=%0b pc_data=%02h, need 1/00", PCincr, pc_data); end
        for (int i = 1; i <= 5; i++) begin
            step(NEXT, 8'h00, 1'b0, 1'b0);
            tests++; if (pc !== 8'(i)) begin failed++;
                $display("FAIL next_seq[%0d]: pc=%02h, need %02h", i, pc, 8'(i)); end
        end
        step(JMP, 8'hFE, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step((i == 1) ? RSVD : NEXT, 8'h00, 1'b0, 1'b0);
            tests++; if (pc !== exp_wrap[i] || fault !== 1'b0) begin failed++;
                $display("FAIL next_wrap[%0d]: pc=%02h fault=%0b, need %02h/0", i, pc, fault, exp_wrap[i]); end
        end
    endtask

    task automatic test_jump();
        do_reset();
        step(JMP, 8'h10, 1'b0, 1'b0);
        step(JMP, 8'h40, 1'b0, 1'b0);
        tests++; if (pc !== 8'h40) begin failed++;
            $display("FAIL jmp: pc=%02h, need 40", pc); end
        step(JCOND, 8'h80, 1'b0, 1'b0);
        tests++; if (pc !== 8'h41) begin failed++;
            $display("FAIL jcond_not_taken: pc=%02h, need 41", pc); end
        step(JCOND, 8'h80, 1'b1, 1'b0);
        tests++; if (pc !== 8'h80) begin failed++;
            $display("FAIL jcond_taken: pc=%02h, need 80", pc); end
        op = JMP; target = 8'h55; stall = 1'b1; #1;
        tests++; if (PCincr !== 1'b0 || pc_data !== 8'h80) begin failed++;
            $display("FAIL stall_drive: PCincr=%0b pc_data=%02h, need 0/80", PCincr, pc_data); end
        step(JMP, 8'h55, 1'b0, 1'b1);
        tests++; if (pc !== 8'h80) begin failed++;
            $display("FAIL stall_jmp: pc=%02h, need 80", pc); end
    endtask

    task automatic test_call_ret();
        logic [7:0] exp_pc [4];
        logic [2:0] exp_d  [4];
        logic [2:0] ops    [4];
        logic [7:0] tgts   [4];
        exp_pc[0] = 8'h20; exp_pc[1] = 8'h30; exp_pc[2] = 8'h22; exp_pc[3] = 8'h06;
        exp_d[0] = 3'd1; exp_d[1] = 3'd2; exp_d[2] = 3'd1; exp_d[3] = 3'd0;
        ops[0] = CALL; ops[1] = CALL; ops[2] = RET; ops[3] = RET;
        tgts[0] = 8'h20; tgts[1] = 8'h30; tgts[2] = 8'h00; tgts[3] = 8'h00;
        do_reset();
        step(JMP, 8'h05, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(ops[i], tgts[i], 1'b0, 1'b0);
            tests++; if (pc !== exp_pc[i] || depth !== exp_d[i]) begin failed++;
                $display("FAIL call_ret[%0d]: pc=%02h depth=%0d, need %02h/%0d", i, pc, depth, exp_pc[i], exp_d[i]); end
            if (i == 0) step(NEXT, 8'h00, 1'b0, 1'b0);  // 20 -> 21
        end
    endtask

    task automatic test_stack_fault();
        do_reset();
        for (int i = 1; i <= 4; i++) step(CALL, 8'(i * 16), 1'b0, 1'b0);
        tests++; if (pc !== 8'h40 || depth !== 3'd4 || fault !== 1'b0) begin failed++;
            $display("FAIL call_fill: pc=%02h depth=%0d fault=%0b, need 40/4/0", pc, depth, fault); end
        step(CALL, 8'h50, 1'b0, 1'b0);
        tests++; if (pc !== 8'h40 || depth !== 3'd4 || fault !== 1'b1) begin failed++;
            $display("FAIL call_overflow: pc=%02h depth=%0d fault=%0b, need 40/4/1", pc, depth, fault); end
        for (int i = 0; i < 10; i++) step((i % 2) ? JMP : RET, 8'h77, 1'b0, i[0]);
        tests++; if (pc !== 8'h40 || fault !== 1'b1 || depth !== 3'd4) begin failed++;
            $display("FAIL fault_frozen: pc=%02h fault=%0b depth=%0d, need 40/1/4", pc, fault, depth); end
        do_reset();
        step(RET, 8'h00, 1'b0, 1'b0);
        tests++; if (pc !== 8'h00 || fault !== 1'b1 || depth !== 3'd0) begin failed++;
            $display("FAIL ret_underflow: pc=%02h fault=%0b depth=%0d, need 00/1/0", pc, fault, depth); end
        step(NEXT, 8'h00, 1'b0, 1'b0);
        tests++; if (pc !== 8'h00) begin failed++;
            $display("FAIL underflow_frozen: pc=%02h, need 00", pc); end
    endtask

    task automatic test_wait();
        do_reset();
        // n=3: PC at 07 for 4 clocks, then 08.
        step(JMP, 8'h07, 1'b0, 1'b0);
        step(WAITOP, 8'hF3, 1'b0, 1'b0);  // upper bits ignored, n=3
        for (int i = 0; i < 2; i++) step(NEXT, 8'h00, 1'b0, 1'b0);
        tests++; if (pc !== 8'h07) begin failed++;
            $display("FAIL wait3_hold: pc=%02h, need 07", pc); end
        step(NEXT, 8'h00, 1'b0, 1'b0);
        tests++; if (pc !== 8'h08) begin failed++;
            $display("FAIL wait3_exit: pc=%02h, need 08", pc); end
        // n=3 with 2 stall cycles: PC at 07 for 6 clocks.
        step(JMP, 8'h07, 1'b0, 1'b0);
        step(WAITOP, 8'h03, 1'b0, 1'b0);
        step(JMP, 8'h99, 1'b0, 1'b1);
        step(NEXT, 8'h00, 1'b0, 1'b1);
        step(NEXT, 8'h00, 1'b0, 1'b0);
        step(NEXT, 8'h00, 1'b0, 1'b0);
        tests++; if (pc !== 8'h07) begin failed++;
            $display("FAIL wait_stall_hold: pc=%02h, need 07", pc); end
        step(NEXT, 8'h00, 1'b0, 1'b0);
        tests++; if (pc !== 8'h08) begin failed++;
            $display("FAIL wait_stall_exit: pc=%02h, need 08", pc); end
        // n=0 behaves as NEXT.
        step(JMP, 8'h07, 1'b0, 1'b0);
        step(WAITOP, 8'hF0, 1'b0, 1'b0);
        tests++; if (pc !== 8'h08) begin failed++;
            $display("FAIL wait0: pc=%02h, need 08", pc); end
    endtask

    task automatic test_halt();
        do_reset();
        step(JMP, 8'h09, 1'b0, 1'b0);
        step(HALT, 8'h00, 1'b0, 1'b0);
        tests++; if (pc !== 8'h09 || halted !== 1'b1 || fault !== 1'b0) begin failed++;
            $display("FAIL halt_enter: pc=%02h halted=%0b fault=%0b, need 09/1/0", pc, halted, fault); end
        for (int i = 0; i < 6; i++) step(3'(i), 8'h33, 1'b1, i[0]);
        tests++; if (pc !== 8'h09 || halted !== 1'b1) begin failed++;
            $display("FAIL halt_frozen: pc=%02h halted=%0b, need 09/1", pc, halted); end
    endtask

    task automatic test_reset_recovery();
        // Reset in HALT with a non-empty stack.
        do_reset();
        step(CALL, 8'h09, 1'b0, 1'b0);
        step(HALT, 8'h00, 1'b0, 1'b0);
        reset = 1'b1; #1;
        tests++; if (halted !== 1'b0 || depth !== 3'd0 || PCincr !== 1'b0 || pc_data !== 8'h00) begin failed++;
            $display("FAIL reset_in_halt: halted=%0b depth=%0d PCincr=%0b pc_data=%02h, need 0/0/0/00",
                     halted, depth, PCincr, pc_data); end
        @(posedge clk); #1 reset = 1'b0;
        tests++; if (pc !== 8'h00) begin failed++;
            $display("FAIL reset_halt_pc: pc=%02h, need 00", pc); end
        // Reset mid-WAIT: afterwards the sequencer must be back in RUN.
        step(JMP, 8'h07, 1'b0, 1'b0);
        step(WAITOP, 8'h05, 1'b0, 1'b0);
        step(NEXT, 8'h00, 1'b0, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        tests++; if (pc !== 8'h00 || halted !== 1'b0 || fault !== 1'b0 || depth !== 3'd0) begin failed++;
            $display("FAIL reset_in_wait: pc=%02h halted=%0b fault=%0b depth=%0d, need 00/0/0/0",
                     pc, halted, fault, depth); end
        step(NEXT, 8'h00, 1'b0, 1'b0);
        tests++; if (pc !== 8'h01) begin failed++;
            $display("FAIL post_wait_reset_run: pc=%02h, need 01", pc); end
        // Reset in FAULT clears fault.
        step(RET, 8'h00, 1'b0, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        tests++; if (fault !== 1'b0 || pc !== 8'h00) begin failed++;
            $display("FAIL reset_in_fault: fault=%0b pc=%02h, need 0/00", fault, pc); end
    endtask

    initial begin
        test_reset();
        test_next();
        test_jump();
        test_call_ret();
        test_stack_fault();
        test_wait();
        test_halt();
        test_reset_recovery();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    // Safety net against a hung run.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, need finish before 100000");
        $fatal(1, "timeout");
    end

endmodule
